axi_config_wr: RTL and testbench

- AXI4 write-channel slave that turns each accepted write burst into a stream of single-cycle register write strobes (wr/waddr/wdata/wstrb) for a simple configuration register file.
- Write-side companion of the config read bridge; both share one register file.
- One burst in flight. No buffering beyond one beat. The register side always accepts writes (no backpressure).

---
 rtl/axi_config_wr.sv | 110 +++++++++++
 tb/tb_axi_config_wr.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_config_wr.sv
// rtl/axi_config_wr.sv - AXI4 write-channel slave producing single-cycle register write strobes
module axi_config_wr #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_INCR  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic                  fixed_q;
  logic                  err_q;
  logic                  aw_hs, w_hs, b_hs, last_beat, beat_err;
  logic                  unused_awsize;

  // Beats are always full width, so the size field carries no information.
  assign unused_awsize = ^s_axi_awsize;

  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign b_hs      = s_axi_bvalid && s_axi_bready;
  assign last_beat = (cnt_q == len_q);
  assign beat_err  = (s_axi_wlast != last_beat);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (aw_hs) state_n = DATA;
      DATA:    if (w_hs && last_beat) state_n = RESP;
      RESP:    if (b_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= 2'b00;
      wr            <= 1'b0;
      waddr         <= '0;
      wdata         <= '0;
      wstrb         <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      fixed_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // Handshake readies are registered copies of the next state.
      s_axi_awready <= (state_n == IDLE);
      s_axi_wready  <= (state_n == DATA);
      s_axi_bvalid  <= (state_n == RESP);
      wr            <= w_hs;
      if (aw_hs) begin
        s_axi_bid <= s_axi_awid;
        addr_q    <= s_axi_awaddr;
        len_q     <= s_axi_awlen;
        fixed_q   <= (s_axi_awburst == 2'd0);
        cnt_q     <= '0;
        err_q     <= 1'b0;
      end
      if (w_hs) begin
        waddr <= addr_q;
        wdata <= s_axi_wdata;
        wstrb <= s_axi_wstrb;
        cnt_q <= cnt_q + 8'd1;
        err_q <= err_q | beat_err;
        if (!fixed_q) addr_q <= addr_q + ADDR_WIDTH'(ADDR_INCR);
        if (last_beat) s_axi_bresp <= (err_q | beat_err) ? 2'b10 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_axi_config_wr.sv
// tb/tb_axi_config_wr.sv - randomized self-checking bench for axi_config_wr
module tb_axi_config_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axi_awid = '0;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'd2;
  logic [1:0]  s_axi_awburst = 2'd1;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [7:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic        wr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  axi_config_wr dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] obs_addr[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Every cycle passes through here: register strobes are compared against the model queue.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (rst_n && wr) begin
      obs_addr.push_back(waddr);
      if (exp_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("waddr", waddr, e.a);
        chk("wdata", wdata, e.d);
        chk("wstrb", 32'(wstrb), 32'(e.s));
      end
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return s_axi_awready;
      1:       return s_axi_wready;
      default: return s_axi_bvalid;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which);
    int n = 0;
    while (!sig(which) && n < 1000) begin
      tick();
      n++;
    end
    if (!sig(which)) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int mode, input int maxgap,
                           input int bhold, input int abort_at, output logic [1:0] got_bresp);
    logic [31:0] d[256];
    logic [3:0]  s[256];
    logic        wl[256];
    logic        err = 1'b0;
    int          nb = int'(len) + 1;
    logic [1:0]  exp_resp;
    got_bresp = 2'bxx;
    for (int i = 0; i < nb; i++) begin
      d[i] = $urandom;
      s[i] = 4'($urandom_range(0, 15));
      case (mode)
        0:       wl[i] = (i == nb - 1);
        1:       wl[i] = (i == 0);
        2:       wl[i] = 1'b0;
        default: wl[i] = 1'($urandom_range(0, 1));
      endcase
      if (wl[i] != (i == nb - 1)) err = 1'b1;
      exp_q.push_back('{addr + ((burst == 2'd0) ? 32'd0 : 32'(i) * 32'd4), d[i], s[i]});
    end
    exp_resp = err ? 2'b10 : 2'b00;

    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    wait_for("awready", 0);
    tick();
    s_axi_awvalid = 1'b0;

    for (int i = 0; i < nb; i++) begin
      if (i == abort_at) begin
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wready", 32'(s_axi_wready), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("rst_pending", 32'(exp_q.size()), 32'(nb - abort_at));
        exp_q.delete();
        tick();
        chk("rst_awready_low", 32'(s_axi_awready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_awready_rise", 32'(s_axi_awready), 32'd1);
        return;
      end
      repeat ($urandom_range(0, maxgap)) tick();
      s_axi_wvalid = 1'b1; s_axi_wdata = d[i]; s_axi_wstrb = s[i]; s_axi_wlast = wl[i];
      wait_for("wready", 1);
      tick();
      s_axi_wvalid = 1'b0;
      s_axi_wlast  = 1'b0;
    end

    wait_for("bvalid", 2);
    for (int h = 0; h < bhold; h++) begin
      chk("hold_bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("hold_bid", 32'(s_axi_bid), 32'(id));
      chk("hold_bresp", 32'(s_axi_bresp), 32'(exp_resp));
      chk("hold_awready", 32'(s_axi_awready), 32'd0);
      tick();
    end
    s_axi_bready = 1'b1;
    chk("bid", 32'(s_axi_bid), 32'(id));
    chk("bresp", 32'(s_axi_bresp), 32'(exp_resp));
    got_bresp = s_axi_bresp;
    tick();
    s_axi_bready = 1'b0;
    chk("b_done_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("b_done_awready", 32'(s_axi_awready), 32'd1);
    chk("pulse_count", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [1:0] r;
    tick();
    chk("reset_awready", 32'(s_axi_awready), 32'd0);
    chk("reset_wready", 32'(s_axi_wready), 32'd0);
    chk("reset_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("reset_wr", 32'(wr), 32'd0);
    chk("reset_bid_bresp", {22'd0, s_axi_bid, s_axi_bresp}, 32'd0);
    chk("reset_waddr", waddr, 32'd0);
    chk("reset_wdata", wdata, 32'd0);
    chk("reset_wstrb", 32'(wstrb), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("awready_after_reset", 32'(s_axi_awready), 32'd1);

    // Single beat with W presented together with AW; exact cycle timing checked.
    exp_q.push_back('{32'h100, 32'hDEADBEEF, 4'hF});
    s_axi_awid = 8'h5; s_axi_awaddr = 32'h100; s_axi_awlen = 8'd0; s_axi_awburst = 2'd1;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
    chk("t1_wready_c0", 32'(s_axi_wready), 32'd0);
    tick();
    s_axi_awvalid = 1'b0;
    chk("t1_awready_c1", 32'(s_axi_awready), 32'd0);
    chk("t1_wready_c1", 32'(s_axi_wready), 32'd1);
    chk("t1_wr_c1", 32'(wr), 32'd0);
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk("t1_wr_c2", 32'(wr), 32'd1);
    chk("t1_waddr", waddr, 32'h100);
    chk("t1_wdata", wdata, 32'hDEADBEEF);
    chk("t1_bvalid_c2", 32'(s_axi_bvalid), 32'd1);
    chk("t1_wready_c2", 32'(s_axi_wready), 32'd0);
    chk("t1_bid", 32'(s_axi_bid), 32'h5);
    chk("t1_bresp", 32'(s_axi_bresp), 32'd0);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk("t1_bvalid_done", 32'(s_axi_bvalid), 32'd0);
    chk("t1_awready_back", 32'(s_axi_awready), 32'd1);

    obs_addr.delete();
    run_burst(8'h11, 32'h40, 8'd3, 2'd1, 0, 3, 0, -1, r);
    chk("incr_count", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() == 4) begin
      chk("incr_a0", obs_addr[0], 32'h40);
      chk("incr_a1", obs_addr[1], 32'h44);
      chk("incr_a2", obs_addr[2], 32'h48);
      chk("incr_a3", obs_addr[3], 32'h4C);
    end
    chk("incr_bresp", 32'(r), 32'd0);

    obs_addr.delete();
    run_burst(8'h22, 32'h20, 8'd2, 2'd0, 0, 1, 0, -1, r);
    chk("fixed_count", 32'(obs_addr.size()), 32'd3);
    foreach (obs_addr[i]) chk("fixed_addr", obs_addr[i], 32'h20);

    run_burst(8'h33, 32'h80, 8'd1, 2'd1, 1, 1, 0, -1, r);
    chk("err_early_wlast", 32'(r), 32'd2);
    run_burst(8'h34, 32'h90, 8'd1, 2'd2, 2, 1, 0, -1, r);
    chk("err_no_wlast", 32'(r), 32'd2);

    run_burst(8'h44, 32'h200, 8'd2, 2'd1, 0, 0, 10, -1, r);
    run_burst(8'h45, 32'h300, 8'd1, 2'd1, 0, 0, 0, -1, r);

    run_burst(8'h55, 32'h400, 8'd7, 2'd1, 0, 0, 0, 3, r);
    run_burst(8'h56, 32'h500, 8'd1, 2'd1, 0, 1, 0, -1, r);
    chk("after_reset_bresp", 32'(r), 32'd0);

    run_burst(8'h66, 32'h1000, 8'd255, 2'd1, 0, 0, 1, -1, r);
    run_burst(8'h67, 32'hFFFF_FFF8, 8'd3, 2'd2, 0, 1, 0, -1, r);

    for (int k = 0; k < 15; k++)
      run_burst(8'($urandom), $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 7)),
                2'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 2,
                int'($urandom_range(0, 3)), -1, r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
